// File: rtl/affine_addr_gen_pkg.sv
// Shared types, default sizes and config-vector slice helpers for the
// affine address generator.
package affine_addr_gen_pkg;

    // Default geometry of the generator.
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned NDIM_DEF   = 3;

    // Upper bounds the slice helpers are sized for.
    localparam int unsigned NDIM_MAX    = 8;
    localparam int unsigned SLICE_MAX_W = 64;
    localparam int unsigned VEC_MAX_W   = NDIM_MAX * SLICE_MAX_W;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Extract slice d of width w from a zero-padded packed config vector.
    function automatic logic [SLICE_MAX_W-1:0] slice_of(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          d,
        input int unsigned          w
    );
        logic [VEC_MAX_W-1:0]   shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = vec >> (d * w);
        if (w >= SLICE_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << w) - 64'd1;
        end
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

    // Per-dimension extent from the packed extent vector.
    function automatic logic [SLICE_MAX_W-1:0] extent_of(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          d,
        input int unsigned          w
    );
        return slice_of(vec, d, w);
    endfunction

    // Per-dimension stride from the packed stride vector.
    function automatic logic [SLICE_MAX_W-1:0] stride_of(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          d,
        input int unsigned          w
    );
        return slice_of(vec, d, w);
    endfunction

endpackage

// File: rtl/addr_dim_counter.sv
// One loop dimension: index counter, latched extent/stride and running
// offset (idx * stride, kept incrementally). offset is the value this
// dimension contributes to the address presented after the current edge.
module addr_dim_counter
    import affine_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              step_in,
    input  logic [CNT_W-1:0]  cfg_extent,
    input  logic [ADDR_W-1:0] cfg_stride,
    output logic [ADDR_W-1:0] offset,
    output logic              at_last,
    output logic              carry_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0]  idx_r;
    logic [CNT_W-1:0]  extent_r;
    logic [ADDR_W-1:0] stride_r;
    logic [ADDR_W-1:0] offset_r;
    logic [CNT_W-1:0]  idx_nxt_s;
    logic [ADDR_W-1:0] offset_nxt_s;
    logic              at_last_s;

    assign at_last_s = (idx_r == (extent_r - CNT_ONE));
    assign at_last   = at_last_s;
    assign carry_out = step_in & at_last_s;
    assign offset    = offset_nxt_s;

    // Next index/offset: clear wins, otherwise step or wrap on carry-in.
    always_comb begin
        idx_nxt_s    = idx_r;
        offset_nxt_s = offset_r;
        if (clear) begin
            idx_nxt_s    = '0;
            offset_nxt_s = '0;
        end else if (step_in) begin
            if (at_last_s) begin
                idx_nxt_s    = '0;
                offset_nxt_s = '0;
            end else begin
                idx_nxt_s    = idx_r + CNT_ONE;
                offset_nxt_s = offset_r + stride_r;
            end
        end else begin
            idx_nxt_s    = idx_r;
            offset_nxt_s = offset_r;
        end
    end

    // Counter state and config latch; a zero extent is latched as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            offset_r <= '0;
            extent_r <= '0;
            stride_r <= '0;
        end else begin
            idx_r    <= idx_nxt_s;
            offset_r <= offset_nxt_s;
            if (load) begin
                extent_r <= (cfg_extent == '0) ? CNT_ONE : cfg_extent;
                stride_r <= cfg_stride;
            end else begin
                extent_r <= extent_r;
                stride_r <= stride_r;
            end
        end
    end

endmodule

// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: walks NDIM nested loops
// (dimension 0 innermost) and emits addr = base + sum(idx_d * stride_d)
// one beat per accepted valid/ready handshake.
module affine_addr_gen
    import affine_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned NDIM   = NDIM_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        cfg_base,
    input  logic [NDIM*CNT_W-1:0]    cfg_extent,
    input  logic [NDIM*ADDR_W-1:0]   cfg_stride,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        addr,
    output logic                     busy,
    output logic                     done
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    logic              fire_s;
    logic              accept_s;
    logic              step_s;
    logic              clear_s;
    logic              last_beat_s;
    logic [NDIM-1:0]   carry_s;
    logic [NDIM-1:0]   carry_out_s;
    logic [NDIM-1:0]   at_last_s;
    logic [ADDR_W-1:0] offset_s [NDIM];
    logic [ADDR_W-1:0] offset_sum_s;
    logic [ADDR_W-1:0] next_addr_s;

    logic [VEC_MAX_W-1:0] extent_pad_s;
    logic [VEC_MAX_W-1:0] stride_pad_s;

    assign out_valid = out_valid_r;
    assign addr      = addr_r;
    assign busy      = busy_r;
    assign done      = done_r;

    assign fire_s   = (state_r == RUN) & out_valid_r & out_ready;
    assign accept_s = (state_r == IDLE) & start & ~abort;
    assign step_s   = fire_s & ~abort;
    assign clear_s  = accept_s | abort;
    // carry_out of every dimension is set only when the whole nest wraps.
    assign last_beat_s = &carry_out_s;

    // Zero-pad the packed config vectors to the slice helpers' width.
    always_comb begin
        extent_pad_s = '0;
        stride_pad_s = '0;
        extent_pad_s[NDIM*CNT_W-1:0]  = cfg_extent;
        stride_pad_s[NDIM*ADDR_W-1:0] = cfg_stride;
    end

    // Ripple carry outward: dimension d steps when all inner ones wrap.
    always_comb begin
        carry_s    = '0;
        carry_s[0] = step_s;
        for (int d = 1; d < NDIM; d++) begin
            carry_s[d] = carry_s[d-1] & at_last_s[d-1];
        end
    end

    generate
        for (genvar g = 0; g < NDIM; g++) begin : g_dim
            addr_dim_counter #(
                .ADDR_W (ADDR_W),
                .CNT_W  (CNT_W)
            ) u_dim (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (accept_s),
                .clear      (clear_s),
                .step_in    (carry_s[g]),
                .cfg_extent (CNT_W'(extent_of(extent_pad_s, g, CNT_W))),
                .cfg_stride (ADDR_W'(stride_of(stride_pad_s, g, ADDR_W))),
                .offset     (offset_s[g]),
                .at_last    (at_last_s[g]),
                .carry_out  (carry_out_s[g])
            );
        end
    endgenerate

    // Offset adder: base plus every dimension's next offset, modulo 2^ADDR_W.
    always_comb begin
        offset_sum_s = '0;
        for (int d = 0; d < NDIM; d++) begin
            offset_sum_s = offset_sum_s + offset_s[d];
        end
        next_addr_s = base_r + offset_sum_s;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, status flags and base latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            base_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
            if (accept_s) begin
                base_r <= cfg_base;
            end else begin
                base_r <= base_r;
            end
        end
    end

    // Output beat registers: hold while stalled, advance on each fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            addr_r      <= '0;
        end else if (abort) begin
            out_valid_r <= 1'b0;
            addr_r      <= addr_r;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            addr_r      <= cfg_base;
        end else if (step_s) begin
            out_valid_r <= ~last_beat_s;
            addr_r      <= next_addr_s;
        end else begin
            out_valid_r <= out_valid_r;
            addr_r      <= addr_r;
        end
    end

endmodule
